// File: rtl/param_P.sv
// Shared operand width for the MAC / divider pair.
// P: width of one MAC factor; products and dividends are 2P bits.
package param_P;
    localparam int P = 8;
endpackage

// File: rtl/mac_divider.sv
// Restoring divider that undoes the MAC: D = A*B + C -> Q = D/B, R = D%B.
// One quotient bit per cycle, start/ready/valid handshake.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start, DD, BB     request, 2P-bit dividend, P-bit divisor
//   ready, valid      idle flag, one-cycle result pulse
//   QQ, RR, div_zero  quotient, remainder, divisor-was-zero flag
module mac_divider #(
    parameter int P = param_P::P
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*P-1:0] DD,
    input  logic [P-1:0]   BB,
    output logic           ready,
    output logic           valid,
    output logic [2*P-1:0] QQ,
    output logic [P-1:0]   RR,
    output logic           div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int            CW   = $clog2(2 * P);
    localparam logic [CW-1:0] LAST = CW'(2 * P - 1);

    state_t         state;
    state_t         state_nx;
    logic [2*P-1:0] dvd;
    logic [2*P-1:0] quo;
    logic [2*P-1:0] quo_nx;
    logic [P-1:0]   dvs;
    logic [P-1:0]   rem;
    logic [P-1:0]   rem_nx;
    logic [P:0]     shifted;
    logic           qbit;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (BB == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign valid = (state == DONE);

    // Stored remainder is always < divisor, so it fits in P bits; only the
    // shifted trial value needs the extra bit.
    always_comb begin
        shifted = {rem, dvd[2*P-1]};
        qbit    = (shifted >= {1'b0, dvs});
        rem_nx  = qbit ? P'(shifted - {1'b0, dvs}) : shifted[P-1:0];
        quo_nx  = {quo[2*P-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            QQ       <= '0;
            RR       <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= DD;
                        dvs <= BB;
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
                        if (BB == '0) begin
                            QQ       <= '1;
                            RR       <= DD[P-1:0];
                            div_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd <= dvd << 1;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        QQ       <= quo_nx;
                        RR       <= rem_nx;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_divider.sv
// Self-checking bench for mac_divider (P=8).
// Directed and random divisions against a plain-arithmetic model.
module tb_mac_divider;

    localparam int P = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*P-1:0] DD;
    logic [P-1:0]   BB;
    logic           ready;
    logic           valid;
    logic [2*P-1:0] QQ;
    logic [P-1:0]   RR;
    logic           div_zero;

    int checks   = 0;
    int failures = 0;

    mac_divider #(.P(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .DD       (DD),
        .BB       (BB),
        .ready    (ready),
        .valid    (valid),
        .QQ       (QQ),
        .RR       (RR),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("wait_ready", 32'(ready), 32'd1);
    endtask

    // One division; optionally pulses start with junk operands in cycle
    // t+abuse to confirm it is ignored.
    task automatic run_div(input logic [15:0] d, input logic [7:0] b,
                           input int abuse);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          lat;
        int          exp_lat;
        logic        busy_ok;
        if (b == 8'd0) begin
            eq = 16'hFFFF;
            er = d[7:0];
            ez = 1'b1;
            exp_lat = 1;
        end else begin
            eq = 16'(d / {8'd0, b});
            er = 8'(d % {8'd0, b});
            ez = 1'b0;
            exp_lat = 2 * P + 1;
        end
        wait_ready();
        start = 1'b1;
        DD = d;
        BB = b;
        step();
        start = 1'b0;
        DD = 16'($urandom);
        BB = 8'($urandom);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (valid === 1'b1) begin
                lat = k;
                break;
            end
            if (ready !== 1'b0) busy_ok = 1'b0;
            start = (k == abuse);
            if (k == abuse) begin
                DD = 16'($urandom);
                BB = 8'($urandom);
            end
            step();
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_not_ready", 32'(busy_ok), 32'd1);
        chk("QQ", 32'(QQ), 32'(eq));
        chk("RR", 32'(RR), 32'(er));
        chk("div_zero", 32'(div_zero), 32'(ez));
        step();
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
        chk("QQ_hold", 32'(QQ), 32'(eq));
    endtask

    initial begin
        logic        seen;
        logic [15:0] rd;
        logic [7:0]  rb;

        rst_n = 1'b0;
        start = 1'b0;
        DD = 16'h0000;
        BB = 8'h00;
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            DD = 16'h1234;
            BB = 8'h00;
            step();
        end
        start = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_QQ", 32'(QQ), 32'd0);
        chk("rst_RR", 32'(RR), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        step();

        run_div(16'hABCD, 8'h12, 0);
        chk("basic_QQ_const", 32'(QQ), 32'h098B);
        run_div(16'h00A1, 8'h0D, 0);
        chk("mac_A", 32'(QQ), 32'h000C);
        chk("mac_C", 32'(RR), 32'h05);
        run_div(16'hFFFF, 8'h01, 0);
        run_div(16'hFFFF, 8'hFF, 0);
        run_div(16'h0005, 8'h09, 0);
        run_div(16'h1234, 8'h00, 0);
        run_div(16'h00A1, 8'h0D, 0);
        run_div(16'hABCD, 8'h12, 5);

        // Reset in the middle of an operation.
        wait_ready();
        start = 1'b1;
        DD = 16'hABCD;
        BB = 8'h12;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (valid === 1'b1) seen = 1'b1;
            step();
        end
        rst_n = 1'b0;
        start = 1'b1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_QQ", 32'(QQ), 32'd0);
        chk("midrst_RR", 32'(RR), 32'd0);
        chk("midrst_div_zero", 32'(div_zero), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (valid === 1'b1) seen = 1'b1;
            step();
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        run_div(16'h4321, 8'h07, 0);

        for (int i = 0; i < 25; i++) begin
            rd = 16'($urandom);
            rb = 8'($urandom);
            if (i % 8 == 3) rb = 8'h00;
            if (i % 8 == 5) rb = 8'($urandom_range(1, 3));
            run_div(rd, rb, (i % 4 == 1) ? int'($urandom_range(1, 16)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_divider.md
# mac_divider

Sequential restoring divider that inverts the multiply-accumulate path: given a 2P-bit value D = A*B + C and the P-bit factor B, it recovers quotient Q = D / B and remainder R = D mod B. When C < B, this gives Q = A and R = C. The block sits downstream of the MAC stage, on the same `clk`, and is parameterised by the shared width P from `param_P`. It uses one quotient bit per cycle, a start/ready/valid handshake, and an explicit divide-by-zero flag.

## Interface
- P, 8 (from `param_P::P`): operand width; the dividend is 2P bits.

- clk  in  1  system clock; all logic acts on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request a division; accepted only while `ready`=1.
- DD  in  2P  dividend, sampled on the accept edge.
- BB  in  P  divisor, sampled on the accept edge.
- ready  out  1  block is idle and can accept `start`.
- valid  out  1  one-cycle pulse: `QQ`/`RR`/`div_zero` are new.
- QQ  out  2P  quotient.
- RR  out  P  remainder.
- div_zero  out  1  the last accepted divisor was 0.

## Operation
- Reset (`rst_n`=0 at an edge), with all values taken after that edge:
  - state = IDLE, `ready`=1, `valid`=0;
  - `QQ`=0, `RR`=0, `div_zero`=0;
  - internal registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `ready`=1.
  - On `start`=1, latch `DD` and `BB` and clear the bit counter.
  - If `BB`≠0, go to RUN. Otherwise go to DONE with `QQ`=all ones, `RR`=`DD[P-1:0]`, `div_zero`=1.
- RUN:
  - Runs exactly 2P cycles, MSB first.
  - Partial remainder is P+1 bits wide and is shifted left with the next dividend bit.
  - If partial remainder ≥ divisor: subtract the divisor and shift a 1 into the quotient. Otherwise shift in a 0.
  - The counter runs 0..2P-1. When it reaches 2P-1, go to DONE.
  - Leaving RUN, `QQ` and `RR` load the final quotient and remainder, and `div_zero` is set to 0.
- DONE:
  - `valid`=1 for exactly one cycle, then go to IDLE.
- Outputs `QQ`/`RR`/`div_zero` hold their values until the next result is loaded. They do not clear on return to IDLE.
- `start` while `ready`=0 is ignored: no queueing and no effect on the operation in flight.
- `DD`/`BB` changes after the accept edge have no effect.
- Arithmetic rules:
  - `QQ` is full 2P bits; with D up to 2^(2P)-1 and B=1, Q fills all 2P bits.
  - `RR` < `BB` always holds when `div_zero`=0.
  - The subtraction never underflows, because it is only done when partial remainder ≥ divisor.

## Timing
- Accept edge is at cycle t (`start`=1, `ready`=1).
- Divisor ≠ 0:
  - `ready`=0 from t+1 through t+2P+1;
  - `valid`=1 during cycle t+2P+1, with results stable in that cycle;
  - `ready`=1 again at t+2P+2.
- Latency is 2P+1 cycles; for P=8, `valid` is high in cycle t+17.
- Divisor = 0: `valid`=1 during cycle t+1, and `ready`=1 at t+2.
- Throughput: at most one division per 2P+2 cycles. A `start` held high through the `valid` cycle is accepted at the first cycle where `ready`=1.
- Reset mid-operation: the next edge with `rst_n`=0 aborts the operation and applies the reset values. No `valid` is produced for the aborted operation.
- Reset and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
All cases use P=8.
- Reset: hold `rst_n`=0 for 3 cycles with `start` toggling -> `ready`=1, `valid`=0, `QQ`=0, `RR`=0, `div_zero`=0.
- Basic division: `DD`=0xABCD, `BB`=0x12 -> `valid` in cycle t+17 with `QQ`=0x098B, `RR`=0x07, `div_zero`=0.
- MAC round trip: A=0x0C, B=0x0D, C=0x05 give `DD`=0x00A1, with `BB`=0x0D -> `QQ`=0x000C, `RR`=0x05.
- Extremes:
  - `DD`=0xFFFF, `BB`=0x01 -> `QQ`=0xFFFF, `RR`=0x00.
  - `DD`=0xFFFF, `BB`=0xFF -> `QQ`=0x0101, `RR`=0x00.
  - `DD`=0x0005, `BB`=0x09 -> `QQ`=0, `RR`=0x05.
- Divide by zero: `DD`=0x1234, `BB`=0x00 -> `valid` in cycle t+1 with `QQ`=0xFFFF, `RR`=0x34, `div_zero`=1. A following valid division clears `div_zero`.
- Protocol abuse:
  - `start` pulsed at t+5 with different operands -> ignored; the result of the first operation is unchanged.
  - `rst_n`=0 at t+8 -> no `valid` and reset values; a fresh `start` then completes normally.
